// File: rtl/hilo_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_mult_unit
// Purpose  : Iterative radix-2 signed/unsigned multiplier with HI/LO result
//            registers, MFHI/MFLO-style registered reads and a busy stall.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_mult_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    input  logic             rd_en,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q,    state_d;
    logic [2*WIDTH-1:0]   mcand_q,    mcand_d;
    logic [WIDTH-1:0]     mplier_q,   mplier_d;
    logic [2*WIDTH-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 neg_q,      neg_d;
    logic [WIDTH-1:0]     hi_q,       hi_d;
    logic [WIDTH-1:0]     lo_q,       lo_d;
    logic                 done_q,     done_d;
    logic [WIDTH-1:0]     rd_data_q,  rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   fix_result;

    assign busy        = (state_q != IDLE);
    assign start_ready = (state_q == IDLE);
    assign stall       = rd_en && busy;
    assign done        = done_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

    // The most-negative value negates to itself, which is its correct
    // unsigned magnitude.
    assign a_mag      = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag      = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign fix_result = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = fix_result[2*WIDTH-1:WIDTH];
                lo_d    = fix_result[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reads see HI/LO as they stand before this edge's FSM update.
        if (rd_en && !busy) begin
            rd_data_d  = rd_sel ? hi_q : lo_q;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_mult_unit
// Purpose  : Directed self-checking bench for hilo_mult_unit (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_mult_unit;

    localparam int C_W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_valid;
    logic           start_ready;
    logic           op_signed;
    logic [C_W-1:0] a;
    logic [C_W-1:0] b;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic           rd_sel;
    logic [C_W-1:0] rd_data;
    logic           rd_valid;
    logic           stall;

    int errors = 0;
    int checks = 0;

    hilo_mult_unit #(.WIDTH(C_W), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_signed   (op_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge; afterwards the unit must be busy.
    task automatic start(input logic sgn, input logic [C_W-1:0] av, input logic [C_W-1:0] bv);
        start_valid = 1'b1;
        op_signed   = sgn;
        a           = av;
        b           = bv;
        tick();
        start_valid = 1'b0;
        a           = 16'hDEAD;
        b           = 16'hBEEF;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ready_after_start", {31'd0, start_ready}, 32'd0);
    endtask

    // Wait (bounded) until done, checking latency and busy duration.
    task automatic wait_done(input string tag);
        int edges = 0;
        int busy_n = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_n++;
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, 17);
        check({tag, "_busy_cycles"}, busy_n, 17);
    endtask

    task automatic read(input string tag, input logic sel, input logic [C_W-1:0] exp);
        rd_en  = 1'b1;
        rd_sel = sel;
        tick();
        rd_en  = 1'b0;
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_rd_data"}, {16'd0, rd_data}, {16'd0, exp});
    endtask

    task automatic mult(input string tag, input logic sgn, input logic [C_W-1:0] av,
                        input logic [C_W-1:0] bv, input logic [C_W-1:0] hi, input logic [C_W-1:0] lo);
        start(sgn, av, bv);
        wait_done(tag);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        read({tag, "_lo"}, 1'b0, lo);
        read({tag, "_hi"}, 1'b1, hi);
    endtask

    initial begin
        int pulses;
        rst         = 1'b0;
        start_valid = 1'b0;
        op_signed   = 1'b0;
        a           = '0;
        b           = '0;
        rd_en       = 1'b0;
        rd_sel      = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, start_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        rst = 1'b1;
        tick();

        mult("u3x5", 1'b0, 16'd3, 16'd5, 16'h0000, 16'h000F);
        mult("umax", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
        mult("sm3x5", 1'b1, 16'hFFFD, 16'd5, 16'hFFFF, 16'hFFF1);
        mult("s8000", 1'b1, 16'h8000, 16'h8000, 16'h4000, 16'h0000);
        mult("sm1m1", 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001);

        // Read and a second start while busy.
        start(1'b0, 16'h1234, 16'h0010);
        tick();
        tick();
        tick();
        rd_en       = 1'b1;
        rd_sel      = 1'b1;
        start_valid = 1'b1;
        a           = 16'hFFFF;
        b           = 16'hFFFF;
        #1;
        check("busy_start_ready", {31'd0, start_ready}, 32'd0);
        pulses = 0;
        begin
            int guard = 0;
            while (done !== 1'b1 && guard < 40) begin
                check("busy_stall", {31'd0, stall}, 32'd1);
                check("busy_no_rd_valid", {31'd0, rd_valid}, 32'd0);
                @(posedge clk);
                #1;
                start_valid = 1'b0;
                guard++;
            end
            check("busy_done_seen", {31'd0, done}, 32'd1);
        end
        check("done_cycle_stall", {31'd0, stall}, 32'd0);
        tick();
        rd_en = 1'b0;
        check("done_read_valid", {31'd0, rd_valid}, 32'd1);
        check("done_read_hi", {16'd0, rd_data}, 32'h0001);
        check("no_queued_start", {31'd0, busy}, 32'd0);
        tick();
        check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
        check("rd_data_hold", {16'd0, rd_data}, 32'h0001);
        read("ignored_lo", 1'b0, 16'h2340);

        // Reset in the middle of RUN.
        mult("pre_rst", 1'b0, 16'd3, 16'd5, 16'h0000, 16'h000F);
        start(1'b0, 16'd7, 16'd9);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, start_ready}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        check("abort_no_done", pulses, 0);
        read("abort_hi", 1'b1, 16'h0000);
        read("abort_lo", 1'b0, 16'h0000);
        mult("u2x2", 1'b0, 16'd2, 16'd2, 16'h0000, 16'h0004);

        // Back-to-back: new start plus a read in the done cycle.
        start(1'b0, 16'd3, 16'd3);
        wait_done("b2b_first");
        check("b2b_ready", {31'd0, start_ready}, 32'd1);
        start_valid = 1'b1;
        op_signed   = 1'b0;
        a           = 16'h0100;
        b           = 16'h0100;
        rd_en       = 1'b1;
        rd_sel      = 1'b0;
        tick();
        start_valid = 1'b0;
        rd_en       = 1'b0;
        check("b2b_accepted", {31'd0, busy}, 32'd1);
        check("b2b_read_valid", {31'd0, rd_valid}, 32'd1);
        check("b2b_read_pre_lo", {16'd0, rd_data}, 32'h0009);
        wait_done("b2b_second");
        tick();
        read("b2b_lo", 1'b0, 16'h0000);
        read("b2b_hi", 1'b1, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Iterative multiplier plus HI/LO register pair for the EX stage. It is the consumer of the HI/LO results that the single-cycle ALU multiply only writes.
- Computes the full 2*WIDTH-bit signed or unsigned product over multiple cycles and stores it in HI/LO.
- Serves MFHI/MFLO-style reads and raises a stall while a multiply is in flight.

Parameters:
- WIDTH, 16, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- start_valid  input  1  request a multiply using a, b, op_signed.
- start_ready  output  1  high only in IDLE; a start is accepted when start_valid && start_ready.
- op_signed  input  1  1 = two's-complement MULT, 0 = MULTU.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- busy  output  1  high in RUN and FIX.
- done  output  1  one-cycle pulse after HI/LO are written.
- rd_en  input  1  read request.
- rd_sel  input  1  0 = LO, 1 = HI.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse; rd_data is valid while it is high.
- stall  output  1  combinational: rd_en && busy.

Behaviour:
- Reset (rst low at an edge):
  - State goes to IDLE; counter, accumulator, HI, LO and rd_data are cleared to 0.
  - done and rd_valid go to 0.
  - Reset during RUN/FIX aborts the operation; HI/LO are not updated with partial results.
- FSM states: IDLE, RUN, FIX.
- IDLE, on accepted start:
  - Latch |a| and |b| (magnitudes if op_signed, raw values otherwise).
  - Latch neg = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the 2*WIDTH-bit accumulator, set counter = 0, go to RUN.
  - Magnitude of the most-negative value (e.g. 0x8000) is taken as an unsigned WIDTH-bit value.
- RUN, one radix-2 step per cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplier right and the multiplicand left; increment the counter.
  - After exactly WIDTH RUN cycles, go to FIX.
- FIX, one cycle:
  - result = neg ? two's-complement of accumulator : accumulator.
  - HI <= result[2W-1:W], LO <= result[W-1:0]; go to IDLE.
  - done = 1 for the following cycle.
- Latency:
  - Start accepted at edge E0; RUN occupies edges E1..E(WIDTH); FIX writes at edge E(WIDTH+1).
  - WIDTH=16 gives 17 edges; done is high in the cycle after E17.
- start_valid while busy: start_ready = 0, the request is ignored and nothing is queued. The requester holds start_valid.
- Reads:
  - rd_en && !busy at edge E: rd_data <= (rd_sel ? HI : LO) and rd_valid = 1 in the cycle after E.
  - rd_en && busy: stall = 1, no read is performed, rd_valid stays 0. The requester holds rd_en until stall drops.
  - A read in the done cycle returns the new HI/LO.
  - Start and read accepted in the same IDLE cycle: the read returns the pre-start HI/LO.
- rd_data holds its last value when rd_valid is 0.
- Operands a and b are sampled only at start acceptance; later changes have no effect.
- Width rule: the full product is exact modulo 2^(2*WIDTH) for all inputs, including unsigned 0xFFFF*0xFFFF and signed 0x8000*0x8000.

Test Plan (WIDTH=16):
- Unsigned 3*5:
  - MULTU a=3, b=5 -> start_ready drops, busy high for 17 cycles.
  - done pulses once; read LO = 0x000F, read HI = 0x0000.
- Unsigned max operands:
  - MULTU 0xFFFF*0xFFFF -> HI = 0xFFFE, LO = 0x0001.
- Signed mixed and negative-max:
  - MULT a=0xFFFD (-3), b=5 -> HI = 0xFFFF, LO = 0xFFF1.
  - MULT 0x8000*0x8000 -> HI = 0x4000, LO = 0x0000.
  - MULT 0xFFFF*0xFFFF (-1*-1) -> HI = 0x0000, LO = 0x0001.
- Read and start during busy:
  - rd_en=1, rd_sel=1 asserted 3 cycles after start -> stall = 1 each busy cycle, rd_valid = 0.
  - In the done cycle stall = 0; the next cycle shows rd_valid = 1 with the new HI.
  - A second start_valid during busy is ignored: HI/LO reflect only the first operation.
- Reset mid-operation:
  - Complete 3*5, then start 7*9 and pull rst low at RUN cycle 8.
  - After reset: busy = 0, done never pulses, HI = LO = 0, start_ready = 1.
  - A new 2*2 then yields LO = 0x0004.
- Back-to-back operations:
  - Start 0x0100*0x0100 in the done cycle of the previous op -> accepted.
  - After 17 cycles: HI = 0x0001, LO = 0x0000.
